// File: rtl/peri_pkg.sv
// peri_pkg: shared definitions for the peripheral register fabric.
//   state_e    - request FSM states (IDLE / WAIT / RESP)
//   TMO_RDATA  - read data returned when a slave times out
//   SEL_*      - slave-select codes (upper address bits) of the standard peripherals
package peri_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] TMO_RDATA = 32'hFFFF_FFFF;

    localparam logic [3:0] SEL_UART  = 4'd0;
    localparam logic [3:0] SEL_GPIO  = 4'd1;
    localparam logic [3:0] SEL_RTC   = 4'd2;
    localparam logic [3:0] SEL_TIMER = 4'd3;

endpackage

// File: rtl/peri_reg_fabric_if.sv
// peri_reg_fabric_if: register-bus master port plus the fanned-out slave channels.
//   reg_*  - master request (cs/wr/addr/wdata/be) and response (rdata/ack/err)
//   slv_*  - one-hot slave select, registered request copy, per-slave rdata/ack
// Modports:
//   master - the host and peripherals side (drives reg_* requests and slave responses)
//   slave  - the fabric itself (peri_reg_fabric)
interface peri_reg_fabric_if #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned SEL_W   = 4
);
    logic                      reg_cs;
    logic                      reg_wr;
    logic [ADDR_W-1:0]         reg_addr;
    logic [31:0]               reg_wdata;
    logic [3:0]                reg_be;
    logic [31:0]               reg_rdata;
    logic                      reg_ack;
    logic                      reg_err;

    logic [NUM_SLV-1:0]        slv_cs;
    logic                      slv_wr;
    logic [ADDR_W-SEL_W-1:0]   slv_addr;
    logic [31:0]               slv_wdata;
    logic [3:0]                slv_be;
    logic [NUM_SLV*32-1:0]     slv_rdata;
    logic [NUM_SLV-1:0]        slv_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack, reg_err,
        input  slv_cs, slv_wr, slv_addr, slv_wdata, slv_be,
        output slv_rdata, slv_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack, reg_err,
        output slv_cs, slv_wr, slv_addr, slv_wdata, slv_be,
        input  slv_rdata, slv_ack
    );
endinterface

// File: rtl/peri_tmo_cnt.sv
// peri_tmo_cnt: slave-wait timeout counter, only built with PERI_FABRIC_TIMEOUT_EN.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears the count
//   run  - high while the fabric waits on a slave; low clears the count
//   hit  - the count reaches TMO_CYC in the current wait cycle
`ifdef PERI_FABRIC_TIMEOUT_EN
module peri_tmo_cnt #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic hit
);
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_inc;

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + 17'd1;
        cnt_d   = run ? cnt_inc[15:0] : '0;
    end

    // cnt_inc is the number of wait cycles including the current one.
    assign hit = run && (cnt_inc == 17'(TMO_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`endif

// File: rtl/peri_reg_fabric.sv
// peri_reg_fabric: decodes a register-bus request onto one of NUM_SLV peripheral
// channels and returns the slave response as a one-cycle ack.
//   mclk    - the only clock, rising edge
//   s_reset - synchronous active-high reset
//   bus     - peri_reg_fabric_if.slave (reg_* master port, slv_* slave channels)
// Optional feature: define PERI_FABRIC_TIMEOUT_EN to end a slave wait after
// TMO_CYC cycles with reg_err=1 and rdata=TMO_RDATA.
module peri_reg_fabric
    import peri_pkg::*;
#(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned TMO_CYC = 255
) (
    input logic              mclk,
    input logic              s_reset,
    peri_reg_fabric_if.slave bus
);
    localparam int unsigned OFS_W = ADDR_W - SEL_W;

    if (NUM_SLV < 1 || NUM_SLV > 16 || TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_param
        $error("peri_reg_fabric: NUM_SLV or TMO_CYC out of range");
    end

    state_e           state_q, state_d;
    logic             wr_q, wr_d;
    logic [OFS_W-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] req_sel;
    logic             sel_ack;
    logic [31:0]      sel_rdata;
    logic             tmo_hit;

    assign req_sel = bus.reg_addr[ADDR_W-1 -: SEL_W];

    // Only the selected slave's ack/rdata are ever looked at.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (32'(sel_q) == i) begin
                sel_ack   = bus.slv_ack[i];
                sel_rdata = bus.slv_rdata[32*i +: 32];
            end
        end
    end

`ifdef PERI_FABRIC_TIMEOUT_EN
    peri_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo_cnt (
        .clk (mclk),
        .rst (s_reset),
        .run (state_q == ST_WAIT),
        .hit (tmo_hit)
    );
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge mclk) begin
        if (s_reset) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state and captured request/response
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.reg_cs) begin
                    wr_d    = bus.reg_wr;
                    addr_d  = bus.reg_addr[OFS_W-1:0];
                    wdata_d = bus.reg_wdata;
                    be_d    = bus.reg_be;
                    sel_d   = req_sel;
                    rdata_d = '0;
                    if (32'(req_sel) < NUM_SLV) begin
                        err_d   = 1'b0;
                        state_d = ST_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // An ack in the timeout cycle wins over the timeout.
                if (sel_ack) begin
                    rdata_d = wr_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    rdata_d = wr_q ? '0 : TMO_RDATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.reg_ack   = 1'b0;
        bus.reg_err   = 1'b0;
        bus.reg_rdata = '0;
        bus.slv_cs    = '0;
        if (state_q == ST_RESP) begin
            bus.reg_ack   = 1'b1;
            bus.reg_err   = err_q;
            bus.reg_rdata = rdata_q;
        end
        if (state_q == ST_WAIT) begin
            for (int unsigned i = 0; i < NUM_SLV; i++) begin
                if (32'(sel_q) == i) begin
                    bus.slv_cs[i] = 1'b1;
                end
            end
        end
    end

    assign bus.slv_wr    = wr_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.slv_be    = be_q;

endmodule
